// File: rtl/counter_run_scheduler.sv
// Round-robin run scheduler driving a shared 4-bit counter through fixed-length runs.
// Two requesters; a granted run counts up/down/even/odd for len steps at a prescaled rate.
module counter_run_scheduler #(
  parameter int unsigned PRESCALE = 0
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] req,
  input  logic [1:0] mode0,
  input  logic [1:0] mode1,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic       abort,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic [1:0] cur_mode,
  output logic [3:0] Cout
);

  localparam logic [3:0] PRESC_MAX = 4'(PRESCALE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] cout_q, cout_d;
  logic [4:0] rem_q, rem_d;
  logic [3:0] presc_q, presc_d;
  logic       last_q, last_d;

  logic       win;
  logic [1:0] win_mode;
  logic [3:0] win_len;
  logic [3:0] start_val;
  logic [3:0] next_cout;

  // Contention goes to whichever requester was not granted last.
  always_comb begin
    unique case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ~last_q;
    endcase
    win_mode = win ? mode1 : mode0;
    win_len  = win ? len1  : len0;
  end

  always_comb begin
    unique case (win_mode)
      2'b01:   start_val = 4'hF;
      2'b11:   start_val = 4'h1;
      default: start_val = 4'h0;
    endcase
  end

  // Even and odd both step by two; modulo-16 wrap keeps parity.
  always_comb begin
    unique case (mode_q)
      2'b00:   next_cout = cout_q + 4'd1;
      2'b01:   next_cout = cout_q - 4'd1;
      default: next_cout = cout_q + 4'd2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    cout_d  = cout_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d = S_RUN;
          gnt_d   = win ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          mode_d  = win_mode;
          rem_d   = (win_len == 4'd0) ? 5'd16 : {1'b0, win_len};
          cout_d  = start_val;
          presc_d = '0;
          last_d  = win;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          cout_d  = next_cout;
          rem_d   = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= '0;
      cout_q  <= '0;
      rem_q   <= '0;
      presc_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      cout_q  <= cout_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
      last_q  <= last_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cur_mode = mode_q;
  assign Cout     = cout_q;

endmodule

// File: tb/tb_counter_run_scheduler.sv
// Bench for counter_run_scheduler: two instances (PRESCALE 0 and 2) on shared stimulus,
// checked every cycle against a run-level arithmetic model, plus directed scenario checks.
module tb_counter_run_scheduler;

  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] req, mode0, mode1;
  logic [3:0] len0, len1;
  logic       abort;

  logic [1:0] gnt0, gnt2, cmode0, cmode2;
  logic       busy0, busy2, done0, done2;
  logic [3:0] cout0, cout2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_run_scheduler #(.PRESCALE(0)) u0 (
    .clk(clk), .clear(clear), .req(req), .mode0(mode0), .mode1(mode1),
    .len0(len0), .len1(len1), .abort(abort),
    .gnt(gnt0), .busy(busy0), .done(done0), .cur_mode(cmode0), .Cout(cout0)
  );

  counter_run_scheduler #(.PRESCALE(2)) u2 (
    .clk(clk), .clear(clear), .req(req), .mode0(mode0), .mode1(mode1),
    .len0(len0), .len1(len1), .abort(abort),
    .gnt(gnt2), .busy(busy2), .done(done2), .cur_mode(cmode2), .Cout(cout2)
  );

  // Run-level model: a run is (start, delta, N); output after t cycles is start + (t/(P+1))*delta.
  int m_P[2] = '{0, 2};
  int m_active[2], m_t[2], m_N[2], m_start[2], m_delta[2];
  int m_owner[2], m_mode[2], m_hold[2], m_last[2];

  function automatic int cout_at(int k, int steps);
    return (m_start[k] + steps * m_delta[k]) % 16;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_t[k] = 0; m_hold[k] = 0; m_mode[k] = 0; m_last[k] = 1;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int dur;
      dur = m_N[k] * (m_P[k] + 1);
      if (m_active[k] == 0) begin
        if (req != 2'b00) begin
          int md, ln;
          if (req == 2'b01)      m_owner[k] = 0;
          else if (req == 2'b10) m_owner[k] = 1;
          else                   m_owner[k] = (m_last[k] == 0) ? 1 : 0;
          m_last[k]   = m_owner[k];
          md          = (m_owner[k] == 0) ? int'(mode0) : int'(mode1);
          ln          = (m_owner[k] == 0) ? int'(len0)  : int'(len1);
          m_mode[k]   = md;
          m_N[k]      = (ln == 0) ? 16 : ln;
          m_start[k]  = (md == 1) ? 15 : (md == 3) ? 1 : 0;
          m_delta[k]  = (md == 0) ? 1 : (md == 1) ? 15 : 2;
          m_t[k]      = 0;
          m_active[k] = 1;
        end
      end else if (m_t[k] < dur) begin
        if (abort) begin
          m_active[k] = 0;
          m_hold[k]   = cout_at(k, m_t[k] / (m_P[k] + 1));
        end else begin
          m_t[k]++;
        end
      end else begin
        m_active[k] = 0;
        m_hold[k]   = cout_at(k, m_N[k]);
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, k * 2, obs, expv);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] eg, eb, ed, ec, em;
      if (m_active[k] != 0) begin
        eg = 8'(1 << m_owner[k]);
        eb = 8'd1;
        ed = (m_t[k] == m_N[k] * (m_P[k] + 1)) ? 8'd1 : 8'd0;
        ec = 8'(cout_at(k, m_t[k] / (m_P[k] + 1)));
      end else begin
        eg = 8'd0; eb = 8'd0; ed = 8'd0;
        ec = 8'(m_hold[k]);
      end
      em = 8'(m_mode[k]);
      chk("gnt",      k, (k == 0) ? {6'd0, gnt0}   : {6'd0, gnt2},   eg);
      chk("busy",     k, (k == 0) ? {7'd0, busy0}  : {7'd0, busy2},  eb);
      chk("done",     k, (k == 0) ? {7'd0, done0}  : {7'd0, done2},  ed);
      chk("Cout",     k, (k == 0) ? {4'd0, cout0}  : {4'd0, cout2},  ec);
      chk("cur_mode", k, (k == 0) ? {6'd0, cmode0} : {6'd0, cmode2}, em);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Called just after tick(): clear pulses low strictly between clock edges.
  task automatic pulse_clear();
    #2 clear = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 clear = 1'b1;
  endtask

  task automatic wait_idle();
    req   = 2'b00;
    abort = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (m_active[0] == 0 && m_active[1] == 0) break;
      tick();
    end
    chk("idle_busy", 0, {7'd0, busy0}, 8'd0);
    chk("idle_busy", 1, {7'd0, busy2}, 8'd0);
  endtask

  initial begin
    clear = 1'b0; req = '0; mode0 = '0; mode1 = '0; len0 = '0; len1 = '0; abort = 1'b0;
    model_reset();
    #3 check_all();
    chk("rst_cout", 0, {4'd0, cout0}, 8'd0);
    #5 clear = 1'b1;

    // Up-count run of 3 from requester 0
    req = 2'b01; mode0 = 2'b00; len0 = 4'd3;
    tick();
    chk("r029_c0", 0, {4'd0, cout0}, 8'd0);
    chk("r029_g",  0, {6'd0, gnt0}, 8'd1);
    req = 2'b00;
    tick(); chk("r029_c1", 0, {4'd0, cout0}, 8'd1);
    tick(); chk("r029_c2", 0, {4'd0, cout0}, 8'd2);
    tick(); chk("r029_c3", 0, {4'd0, cout0}, 8'd3);
    chk("r029_done", 0, {7'd0, done0}, 8'd1);
    tick(); chk("r029_gend", 0, {6'd0, gnt0}, 8'd0);
    chk("r029_dend", 0, {7'd0, done0}, 8'd0);
    wait_idle();

    // Contention from reset preference, alternating grants
    tick(); pulse_clear();
    req = 2'b11; mode0 = 2'b00; mode1 = 2'b00; len0 = 4'd2; len1 = 4'd2;
    tick(); chk("r030_g1", 0, {6'd0, gnt0}, 8'd1);
    tick(); tick(); tick(); chk("r030_gap1", 0, {6'd0, gnt0}, 8'd0);
    tick(); chk("r030_g2", 0, {6'd0, gnt0}, 8'd2);
    tick(); tick(); tick(); chk("r030_gap2", 0, {6'd0, gnt0}, 8'd0);
    tick(); chk("r030_g3", 0, {6'd0, gnt0}, 8'd1);
    wait_idle();

    // Odd mode with length 0 = 16 steps
    req = 2'b01; mode0 = 2'b11; len0 = 4'd0;
    tick(); chk("r031_c0", 0, {4'd0, cout0}, 8'd1);
    req = 2'b00;
    for (int s = 1; s <= 16; s++) begin
      tick();
      chk("r031_c", 0, {4'd0, cout0}, 8'((1 + 2 * s) % 16));
      chk("r031_d", 0, {7'd0, done0}, (s == 16) ? 8'd1 : 8'd0);
    end
    tick(); chk("r031_fin", 0, {4'd0, cout0}, 8'd1);
    chk("r031_nodone", 0, {7'd0, done0}, 8'd0);
    wait_idle();

    // Down run of 5 aborted after two steps
    req = 2'b01; mode0 = 2'b01; len0 = 4'd5;
    tick(); chk("r032_c0", 0, {4'd0, cout0}, 8'd15);
    req = 2'b00;
    tick(); chk("r032_c1", 0, {4'd0, cout0}, 8'd14);
    tick(); chk("r032_c2", 0, {4'd0, cout0}, 8'd13);
    abort = 1'b1;
    tick(); chk("r032_frz", 0, {4'd0, cout0}, 8'd13);
    chk("r032_busy", 0, {7'd0, busy0}, 8'd0);
    chk("r032_done", 0, {7'd0, done0}, 8'd0);
    abort = 1'b0;
    tick(); chk("r032_hold", 0, {4'd0, cout0}, 8'd13);
    wait_idle();

    // Prescaled even run of 2 on the PRESCALE=2 instance
    req = 2'b01; mode0 = 2'b10; len0 = 4'd2;
    tick(); chk("r033_c", 1, {4'd0, cout2}, 8'd0);
    req = 2'b00;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("r033_c", 1, {4'd0, cout2}, (c < 3) ? 8'd0 : (c < 6) ? 8'd2 : 8'd4);
      chk("r033_d", 1, {7'd0, done2}, (c == 6) ? 8'd1 : 8'd0);
    end
    wait_idle();

    // Asynchronous clear mid-run
    req = 2'b01; mode0 = 2'b00; len0 = 4'd8;
    tick(); req = 2'b00;
    tick(); tick(); tick();
    pulse_clear();
    chk("r034_busy", 0, {7'd0, busy0}, 8'd0);
    chk("r034_cout", 0, {4'd0, cout0}, 8'd0);
    req = 2'b11;
    tick(); chk("r034_g", 0, {6'd0, gnt0}, 8'd1);
    chk("r034_g", 1, {6'd0, gnt2}, 8'd1);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req   = 2'($urandom_range(0, 3));
      mode0 = 2'($urandom_range(0, 3));
      mode1 = 2'($urandom_range(0, 3));
      len0  = 4'($urandom_range(0, 15));
      len1  = 4'($urandom_range(0, 15));
      abort = ($urandom_range(0, 11) == 0);
      tick();
      if ($urandom_range(0, 79) == 0) pulse_clear();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
